// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop synchronizer, shared tick prescaler and one
// debounce/auto-repeat FSM per button producing level, press, release and repeat.
module btn_conditioner #(
    parameter int N_BTN          = 3,
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             tick
);

    localparam int MAX_DR = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
    localparam int CW     = $clog2(MAX_P + 1);
    localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    // Complete per-button state; rate marks that the first repeat has fired.
    typedef struct packed {
        state_t        state;
        logic          rate;
        logic [CW-1:0] dc;
        logic [CW-1:0] rc;
    } btn_fsm_t;

    localparam btn_fsm_t FSM_RST = '{state: IDLE, rate: 1'b0, dc: '0, rc: '0};

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] s;
    logic [TW-1:0]    div_q;

    btn_fsm_t fsm     [N_BTN];
    btn_fsm_t fsm_nxt [N_BTN];

    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] release_nxt;
    logic [N_BTN-1:0] repeat_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= btn_raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + TW'(1);
        end
    end

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                fsm[i] <= FSM_RST;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_repeat  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                fsm[i] <= fsm_nxt[i];
            end
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_repeat  <= repeat_nxt;
        end
    end

    // A synchronizer drop always wins over a tick in the same cycle.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            fsm_nxt[i]     = fsm[i];
            level_nxt[i]   = btn_level[i];
            press_nxt[i]   = 1'b0;
            release_nxt[i] = 1'b0;
            repeat_nxt[i]  = 1'b0;
            case (fsm[i].state)
                IDLE: begin
                    if (s[i]) begin
                        fsm_nxt[i].state = PRESS_WAIT;
                        fsm_nxt[i].dc    = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s[i]) begin
                        fsm_nxt[i].state = IDLE;
                    end else if (tick) begin
                        if (fsm[i].dc == DB_LAST) begin
                            fsm_nxt[i].state = HELD;
                            fsm_nxt[i].rc    = '0;
                            fsm_nxt[i].rate  = 1'b0;
                            level_nxt[i]     = 1'b1;
                            press_nxt[i]     = 1'b1;
                        end else begin
                            fsm_nxt[i].dc = fsm[i].dc + CW'(1);
                        end
                    end
                end
                HELD: begin
                    if (!s[i]) begin
                        fsm_nxt[i].state = REL_WAIT;
                        fsm_nxt[i].dc    = '0;
                    end else if (tick) begin
                        if ((!fsm[i].rate && fsm[i].rc == RD_LAST) ||
                            ( fsm[i].rate && fsm[i].rc == RR_LAST)) begin
                            fsm_nxt[i].rc   = '0;
                            fsm_nxt[i].rate = 1'b1;
                            repeat_nxt[i]   = 1'b1;
                        end else begin
                            fsm_nxt[i].rc = fsm[i].rc + CW'(1);
                        end
                    end
                end
                REL_WAIT: begin
                    // rc and rate stay frozen so a bounce back into HELD resumes the cadence.
                    if (s[i]) begin
                        fsm_nxt[i].state = HELD;
                    end else if (tick) begin
                        if (fsm[i].dc == DB_LAST) begin
                            fsm_nxt[i].state = IDLE;
                            level_nxt[i]     = 1'b0;
                            release_nxt[i]   = 1'b1;
                        end else begin
                            fsm_nxt[i].dc = fsm[i].dc + CW'(1);
                        end
                    end
                end
                default: begin
                    fsm_nxt[i].state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with small timing parameters; expected
// pulse timing is counted in debounce ticks from each raw input change.
module tb_btn_conditioner;

    localparam int N  = 3;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic         tick;

    int checks = 0;
    int errors = 0;

    int press_cnt [N];
    int rel_cnt   [N];
    int rep_cnt   [N];
    int excl_viol = 0;
    int wide_viol = 0;
    logic [N-1:0] prev_press = '0;
    logic [N-1:0] prev_rel   = '0;
    logic [N-1:0] prev_rep   = '0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN          (N),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .tick        (tick)
    );

    // Pulse accounting on the falling edge, clear of the driving edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   press_cnt[i]++;
            if (btn_release[i]) rel_cnt[i]++;
            if (btn_repeat[i])  rep_cnt[i]++;
            if (int'(btn_press[i]) + int'(btn_release[i]) + int'(btn_repeat[i]) > 1) excl_viol++;
            if ((btn_press[i] && prev_press[i]) || (btn_release[i] && prev_rel[i]) ||
                (btn_repeat[i] && prev_rep[i])) wide_viol++;
        end
        prev_press = btn_press;
        prev_rel   = btn_release;
        prev_rep   = btn_repeat;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle where the n-th tick (counting the current cycle) is seen.
    task automatic count_ticks(input int n);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        while (1) begin
            if (tick) seen++;
            if (seen >= n) break;
            if (guard > 20 * TD * n) begin
                check("tick_timeout", guard, 0);
                break;
            end
            step();
            guard++;
        end
    endtask

    initial begin
        int n;
        int guard;
        int rel_snap;
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            rep_cnt[i]   = 0;
        end

        // Reset and clean press on bit 0
        repeat (3) begin
            step();
            check("reset_outputs", {btn_level, btn_press, btn_release, btn_repeat, tick}, 0);
        end
        rst_n      = 1'b1;
        btn_raw[0] = 1'b1;
        step();
        check("tick_c1", tick, 0);
        step();
        check("tick_c2", tick, 0);
        step();
        check("tick_c3", tick, 1);
        count_ticks(DT);
        check("press0_early", btn_press[0], 0);
        step();
        check("press0_pulse", btn_press[0], 1);
        check("level0_rise", btn_level[0], 1);
        step();
        check("press0_end", btn_press[0], 0);
        check("level0_hold", btn_level[0], 1);
        check("press0_count", press_cnt[0], 1);
        step();
        step();
        check("tick_period", tick, 1);

        // Bounce rejection on bit 1
        for (int r = 0; r < 4; r++) begin
            btn_raw[1] = 1'b1;
            repeat (6) step();
            btn_raw[1] = 1'b0;
            repeat (2) step();
            check("bounce_level1", btn_level[1], 0);
        end
        repeat (12) step();
        check("bounce_level1_final", btn_level[1], 0);
        check("bounce_press1", press_cnt[1], 0);
        check("bounce_rel1", rel_cnt[1], 0);
        check("bounce_rep1", rep_cnt[1], 0);

        // Release with a one-tick bounce on bit 0
        btn_raw[0] = 1'b0;
        repeat (TD) step();
        btn_raw[0] = 1'b1;
        repeat (TD) step();
        check("rel0_bounce_level", btn_level[0], 1);
        check("rel0_bounce_count", rel_cnt[0], 0);
        btn_raw[0] = 1'b0;
        repeat (3) step();
        count_ticks(DT);
        check("rel0_early", btn_release[0], 0);
        check("level0_before_fall", btn_level[0], 1);
        step();
        check("rel0_pulse", btn_release[0], 1);
        check("level0_fall", btn_level[0], 0);
        step();
        check("rel0_end", btn_release[0], 0);
        check("rel0_count", rel_cnt[0], 1);

        // Auto-repeat on bit 2 over 40 ticks after the press tick
        btn_raw[2] = 1'b1;
        repeat (3) step();
        count_ticks(DT);
        step();
        check("press2_pulse", btn_press[2], 1);
        n     = 0;
        guard = 0;
        while (n < 40 && guard < 40 * TD * 4) begin
            if (tick) begin
                n++;
                step();
                check("rep2_tick", btn_repeat[2], (n >= RD && ((n - RD) % RR) == 0));
            end else begin
                step();
            end
            guard++;
        end
        check("rep2_ticks_seen", n, 40);
        btn_raw[2] = 1'b0;
        repeat (3) step();
        count_ticks(DT);
        step();
        check("rel2_pulse", btn_release[2], 1);
        step();
        check("rep2_total", rep_cnt[2], 18);
        check("rel2_count", rel_cnt[2], 1);

        // Simultaneous press of all buttons
        btn_raw = 3'b111;
        repeat (3) step();
        count_ticks(DT);
        check("press_all_early", btn_press, 3'b000);
        step();
        check("press_all", btn_press, 3'b111);
        check("level_all", btn_level, 3'b111);
        step();
        check("press_all_end", btn_press, 3'b000);

        // Asynchronous reset while all buttons are held
        repeat (3) step();
        rel_snap = rel_cnt[0] + rel_cnt[1] + rel_cnt[2];
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", {btn_level, btn_press, btn_release, btn_repeat, tick}, 0);
        repeat (2) step();
        check("rst_hold_out", {btn_level, btn_press, btn_release, btn_repeat, tick}, 0);
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rst2_tick_c3", tick, 1);
        count_ticks(DT);
        check("rst2_press_early", btn_press, 3'b000);
        step();
        check("rst2_press", btn_press, 3'b111);
        check("rst2_level", btn_level, 3'b111);
        step();
        check("rst2_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], rel_snap);

        check("pulse_exclusive", excl_viol, 0);
        check("pulse_width", wide_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Button front end for the pixel-effect tasks. It turns up to N_BTN raw, bouncy push-button inputs into three outputs per button: clean debounced levels, single-cycle press and release pulses, and auto-repeat pulses.

- `btn_level` feeds the downstream drawing stages that do their own slow-clock edge detection.
- The pulse outputs serve consumers running on `clk`.
- It sits directly between the board button pins and the drawing stages.

## Interface

Parameters:
- `N_BTN`, 3: number of buttons handled.
- `TICK_DIV`, 100000: `clk` cycles per internal debounce tick (1 kHz at 100 MHz).
- `DEBOUNCE_TICKS`, 20: consecutive stable ticks needed to accept a level change; ≥1.
- `REPEAT_DELAY`, 500: ticks held before the first repeat pulse; ≥1.
- `REPEAT_RATE`, 100: ticks between subsequent repeat pulses; ≥1.

Ports:
- `clk`, input, 1: the single clock; every register is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `btn_raw`, input, N_BTN: raw button pins, asynchronous to `clk`, active-high.
- `btn_level`, output, N_BTN: debounced button level, registered.
- `btn_press`, output, N_BTN: one-`clk` pulse when a debounced press is accepted.
- `btn_release`, output, N_BTN: one-`clk` pulse when a debounced release is accepted.
- `btn_repeat`, output, N_BTN: one-`clk` auto-repeat pulse while held.
- `tick`, output, 1: internal debounce tick strobe, exported for debug and bench sync.

## Operation

- **Synchronizer:** two-flop synchronizer per bit on `btn_raw`, giving `s`. Only `s` is used downstream.
- **Prescaler:**
  - Counter runs 0..TICK_DIV-1 and wraps.
  - `tick` is 1 for exactly the cycle the counter equals TICK_DIV-1.
  - Shared by all buttons.
- **Per-button FSM:** states IDLE, PRESS_WAIT, HELD, REL_WAIT. Each button has its own debounce counter `dc` and repeat counter `rc`, sized to hold the largest parameter.
- **IDLE:**
  - `s`=1 → PRESS_WAIT, `dc`=0.
- **PRESS_WAIT:**
  - `s`=0 → IDLE, with no pulse.
  - Otherwise, on `tick`: if `dc`==DEBOUNCE_TICKS-1 → HELD, else `dc`+1.
- **Entering HELD:**
  - `btn_level`=1.
  - `btn_press`=1 for that one cycle.
  - `rc`=0, first-repeat phase.
- **HELD:**
  - `s`=0 → REL_WAIT, `dc`=0.
  - Otherwise, on `tick`, `rc`+1.
  - First phase: when `rc` reaches REPEAT_DELAY-1 on a tick, pulse `btn_repeat`, set `rc`=0 and switch to rate phase.
  - Rate phase: pulse `btn_repeat` each time `rc` reaches REPEAT_RATE-1 on a tick, then set `rc`=0.
- **REL_WAIT:**
  - `s`=1 → HELD, with no pulse. `rc` and the repeat phase are frozen, not reset.
  - Otherwise, on `tick`: if `dc`==DEBOUNCE_TICKS-1 → IDLE, `btn_level`=0, `btn_release` pulse; else `dc`+1.
- **Repeat during bounce:** no `btn_repeat` while in REL_WAIT.
- **Independence:** buttons are fully independent. Simultaneous events on different bits each produce their own pulses in the same cycle.
- **Pulse exclusivity:** `btn_press`, `btn_repeat` and `btn_release` of one bit are never high in the same cycle.

## Timing

- **Reset:**
  - All outputs 0, all FSMs IDLE, prescaler 0, synchronizer flops 0.
  - Asserting `rst_n` mid-operation aborts everything immediately, with no release pulse.
  - A button held through reset deassertion goes through PRESS_WAIT and yields a normal `btn_press`.
- **Input latency:** `btn_raw` change to `s` takes 2 `clk`.
- **Press latency:** from `s` rising, the press is accepted on the DEBOUNCE_TICKS-th `tick` seen while `s` stays 1. That is between (DEBOUNCE_TICKS-1)·TICK_DIV+1 and DEBOUNCE_TICKS·TICK_DIV cycles.
- **Output registration:** `btn_level` and the pulses are registered and change on the same edge as the FSM transition.
- **Rejected glitches:** any glitch shorter than the acceptance window produces no output change.
- **First repeat:** occurs REPEAT_DELAY ticks after the press tick. Later repeats occur every REPEAT_RATE ticks.

## Test plan

Parameters for all tests: TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.

1. **Reset and clean press:**
   - Stimulus: reset low for 3 cycles, then hold `btn_raw[0]`=1.
   - Required: all outputs 0 during reset. `btn_press[0]` is a single 1-cycle pulse on the 3rd tick after `s[0]` rises. `btn_level[0]`=1 from the same edge.
2. **Bounce rejection:**
   - Stimulus: toggle `btn_raw[1]` high for 6 cycles, low for 2, repeated 4 times, then hold low.
   - Required: `btn_level[1]` stays 0 and no pulse ever occurs.
3. **Auto-repeat:**
   - Stimulus: hold `btn_raw[2]` for 40 ticks.
   - Required: `btn_repeat[2]` pulses 5 ticks after press, then every 2 ticks. That is 18 repeat pulses total, each 1 cycle wide.
4. **Release and release bounce:**
   - Stimulus: after a press, drop `btn_raw[0]` for 1 tick, raise it for 1 tick, then drop it permanently.
   - Required: exactly one `btn_release[0]`, 3 ticks after the final drop. `btn_level[0]` falls on that same edge.
5. **Simultaneous buttons:**
   - Stimulus: raise all three bits in the same cycle.
   - Required: `btn_press`=3'b111 in one cycle, with no cross-interference.
6. **Reset mid-hold:**
   - Stimulus: pull `rst_n` low while a button is in HELD.
   - Required: outputs 0 asynchronously with no `btn_release`. After release of reset with the button still held, a fresh `btn_press` occurs.
